// File: rtl/button_conditioner_pkg.sv
// Shared constants and helpers for the button conditioner.
// Holds the default timing constants and the per-channel counter action
// encoding used by the debouncer.
package button_conditioner_pkg;

  localparam int BTN_SAMPLE_CNT_MAX_DEFAULT = 25000;
  localparam int BTN_PULSE_CNT_MAX_DEFAULT  = 150;
  localparam int BTN_SYNC_STAGES_MIN        = 2;

  // What a channel's debounce counter does on a given cycle.
  typedef enum logic [1:0] {
    CNT_HOLD  = 2'd0,  // no sample tick: keep count and state
    CNT_CLEAR = 2'd1,  // tick, input agrees with state: restart count
    CNT_INC   = 2'd2,  // tick, input disagrees, not yet enough ticks
    CNT_FLIP  = 2'd3   // tick, input disagreed long enough: accept it
  } cnt_action_e;

  // Bits needed to hold 0..max_val-1, never less than one bit.
  function automatic int btn_cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage : button_conditioner_pkg

// File: rtl/button_conditioner_sync_chain.sv
// sync_chain: plain N-flop synchroniser, WIDTH bits wide.
// Nothing sits between stages so the synthesis tool sees a clean chain.
// The synchronous reset clears every stage so a freshly reset conditioner
// presents 0 on sync_out until the input has propagated again.
module sync_chain
  import button_conditioner_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = BTN_SYNC_STAGES_MIN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (STAGES < BTN_SYNC_STAGES_MIN) begin : g_bad_stages
    $error("sync_chain: STAGES must be >= %0d", BTN_SYNC_STAGES_MIN);
  end

  logic [WIDTH-1:0] r_stage [STAGES];

  // Shift the raw level through the chain, one stage per clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the stage array is reset element by element; an array of
      // flops gets no implicit reset, and stale stages would leak a level
      // into sync_out right after reset.
      for (int s = 0; s < STAGES; s++) r_stage[s] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the old
      // value of its predecessor; blocking ones would collapse the chain
      // into a single flop.
      r_stage[0] <= i_d;
      for (int s = 1; s < STAGES; s++) r_stage[s] <= r_stage[s-1];
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule : sync_chain

// File: rtl/button_conditioner.sv
// button_conditioner: multi-channel synchroniser + debouncer + edge pulses.
// Each channel is synchronised, then only changes its debounced level after
// PULSE_CNT_MAX consecutive sample ticks that disagree with it. A shared
// timer produces one sample tick every SAMPLE_CNT_MAX cycles.
// Optional feature: define BUTTON_FALL_EDGE_EN to build the fall-edge pulse
// registers; otherwise fall_pulse is tied to zero.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int WIDTH          = 1,
  parameter int SYNC_STAGES    = BTN_SYNC_STAGES_MIN,
  parameter int SAMPLE_CNT_MAX = BTN_SAMPLE_CNT_MAX_DEFAULT,
  parameter int PULSE_CNT_MAX  = BTN_PULSE_CNT_MAX_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] debounced_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  // Parameter legality, reported at elaboration.
  if (WIDTH < 1) begin : g_bad_width
    $error("button_conditioner: WIDTH must be >= 1");
  end
  if (SYNC_STAGES < BTN_SYNC_STAGES_MIN) begin : g_bad_sync
    $error("button_conditioner: SYNC_STAGES must be >= %0d", BTN_SYNC_STAGES_MIN);
  end
  if (SAMPLE_CNT_MAX < 1) begin : g_bad_sample
    $error("button_conditioner: SAMPLE_CNT_MAX must be >= 1");
  end
  if (PULSE_CNT_MAX < 1) begin : g_bad_pulse
    $error("button_conditioner: PULSE_CNT_MAX must be >= 1");
  end

  localparam int TIMER_W = btn_cnt_width(SAMPLE_CNT_MAX);
  localparam int CNT_W   = $clog2(PULSE_CNT_MAX + 1);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SAMPLE_CNT_MAX - 1);
  // One bit wider than the counter so counter+1 never overflows the compare.
  localparam logic [CNT_W:0]     CNT_LAST   = (CNT_W+1)'(PULSE_CNT_MAX);

  logic [TIMER_W-1:0] r_timer;
  logic               w_sample_tick;

  // Synchroniser: one chain instance covers every channel.
  sync_chain #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (async_in),
    .o_q (sync_out)
  );

  // Tick on the last count so SAMPLE_CNT_MAX=1 ticks every cycle.
  assign w_sample_tick = (r_timer == TIMER_LAST);

  // Shared sample timer: counts 0..SAMPLE_CNT_MAX-1 and wraps.
  always_ff @(posedge clk) begin
    if (rst)                r_timer <= '0;
    else if (w_sample_tick) r_timer <= '0;
    else                    r_timer <= r_timer + TIMER_W'(1);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic             r_deb;
    logic             r_rise;
    logic [CNT_W:0]   w_cnt_inc;
    cnt_action_e      w_action;

    assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W+1)'(1);

    // Decide what this channel's counter does this cycle.
    always_comb begin
      // NOTE: default first so every path assigns w_action; a missing
      // branch would otherwise infer a latch.
      w_action = CNT_HOLD;
      if (w_sample_tick) begin
        if (sync_out[i] == r_deb)    w_action = CNT_CLEAR;
        else if (w_cnt_inc == CNT_LAST) w_action = CNT_FLIP;
        else                         w_action = CNT_INC;
      end
    end

    // Debounce counter, accepted level and registered rise pulse.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt  <= '0;
        r_deb  <= 1'b0;
        r_rise <= 1'b0;
      end else begin
        // The pulse is set on the same edge the level flips, so it is high
        // in exactly the first cycle of the new level.
        r_rise <= (w_action == CNT_FLIP) && sync_out[i];
        unique case (w_action)
          CNT_CLEAR: r_cnt <= '0;
          CNT_INC:   r_cnt <= w_cnt_inc[CNT_W-1:0];
          CNT_FLIP: begin
            r_cnt <= '0;
            r_deb <= sync_out[i];
          end
          default:   ;  // CNT_HOLD: count and state stay put
        endcase
      end
    end

    assign debounced_out[i] = r_deb;
    assign rise_pulse[i]    = r_rise;

`ifdef BUTTON_FALL_EDGE_EN
    logic r_fall;

    // Registered fall pulse, aligned with the 1->0 flip of the level.
    always_ff @(posedge clk) begin
      if (rst) r_fall <= 1'b0;
      else     r_fall <= (w_action == CNT_FLIP) && !sync_out[i];
    end

    assign fall_pulse[i] = r_fall;
`endif
  end : g_ch

`ifndef BUTTON_FALL_EDGE_EN
  // Fall detection not built: the port stays for a fixed interface.
  assign fall_pulse = {WIDTH{1'b0}};
`endif

endmodule : button_conditioner

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with WIDTH=2, SYNC_STAGES=2,
// SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3. A per-cycle monitor checks that pulses
// coincide exactly with the first cycle of each new debounced level.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] async_in = 2'b00;
  logic [1:0] sync_out, debounced_out, rise_pulse, fall_pulse;

`ifdef BUTTON_FALL_EDGE_EN
  localparam bit FALL_EN = 1'b1;
`else
  localparam bit FALL_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  button_conditioner #(
    .WIDTH          (2),
    .SYNC_STAGES    (2),
    .SAMPLE_CNT_MAX (4),
    .PULSE_CNT_MAX  (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .async_in      (async_in),
    .sync_out      (sync_out),
    .debounced_out (debounced_out),
    .rise_pulse    (rise_pulse),
    .fall_pulse    (fall_pulse)
  );

  int total = 0;
  int bad   = 0;
  int rise_cnt [2];
  int fall_cnt [2];
  int pulse_err = 0;
  int deb_chg   = 0;
  int n;
  logic [1:0] prev_deb = 2'b00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    for (int k = 0; k < 2; k++) begin
      rise_cnt[k] = 0;
      fall_cnt[k] = 0;
    end
    deb_chg = 0;
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic cyc();
    logic       rst_at_edge;
    logic [1:0] exp_rise, exp_fall;
    rst_at_edge = rst;
    @(posedge clk);
    #1;
    if (rst_at_edge) begin
      exp_rise = 2'b00;
      exp_fall = 2'b00;
    end else begin
      exp_rise = debounced_out & ~prev_deb;
      exp_fall = FALL_EN ? (prev_deb & ~debounced_out) : 2'b00;
    end
    if (rise_pulse !== exp_rise || fall_pulse !== exp_fall) pulse_err++;
    if (debounced_out != prev_deb) deb_chg++;
    for (int k = 0; k < 2; k++) begin
      if (rise_pulse[k]) rise_cnt[k]++;
      if (fall_pulse[k]) fall_cnt[k]++;
    end
    prev_deb = debounced_out;
  endtask

  initial begin
    clear_counts();

    // 1: reset with inputs high, then first cycle after release.
    rst = 1'b1;
    async_in = 2'b11;
    cyc();
    check("rst_c1_sync", 32'(sync_out), 32'd0);
    check("rst_c1_outs", 32'({debounced_out, rise_pulse, fall_pulse}), 32'd0);
    cyc();
    check("rst_c2_sync", 32'(sync_out), 32'd0);
    check("rst_c2_outs", 32'({debounced_out, rise_pulse, fall_pulse}), 32'd0);
    rst = 1'b0;
    cyc();
    check("rel_c1_sync", 32'(sync_out), 32'd0);
    check("rel_c1_outs", 32'({debounced_out, rise_pulse, fall_pulse}), 32'd0);
    async_in = 2'b00;
    repeat (16) cyc();
    check("idle_deb", 32'(debounced_out), 32'd0);

    // 2: clean press on ch0.
    clear_counts();
    async_in[0] = 1'b1;
    cyc();
    check("press_sync_c1", 32'(sync_out[0]), 32'd0);
    cyc();
    check("press_sync_c2", 32'(sync_out[0]), 32'd1);
    n = 2;
    while (debounced_out[0] == 1'b0 && n < 20) begin
      cyc();
      n++;
    end
    check("press_lat_11_14", 32'(n >= 11 && n <= 14), 32'd1);
    check("press_rise_now", 32'(rise_pulse), 32'd1);
    check("press_ch1_quiet", 32'({sync_out[1], debounced_out[1]}), 32'd0);
    cyc();
    check("press_rise_gone", 32'(rise_pulse), 32'd0);
    repeat (4) cyc();
    check("press_rise_cnt", 32'(rise_cnt[0]), 32'd1);
    check("press_deb_held", 32'(debounced_out), 32'd1);

    // 4: release ch0.
    clear_counts();
    async_in[0] = 1'b0;
    n = 0;
    while (debounced_out[0] == 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    check("rel_lat_11_14", 32'(n >= 11 && n <= 14), 32'd1);
    check("rel_fall_now", 32'(fall_pulse[0]), 32'(FALL_EN));
    repeat (4) cyc();
    check("rel_fall_cnt", 32'(fall_cnt[0]), FALL_EN ? 32'd1 : 32'd0);
    check("rel_no_rise", 32'(rise_cnt[0]), 32'd0);

    // 3: bounce every 5 cycles for 60 cycles, then settle low.
    clear_counts();
    for (int t = 0; t < 60; t++) begin
      async_in[0] = ((t / 5) % 2 == 0);
      cyc();
    end
    async_in[0] = 1'b0;
    repeat (20) cyc();
    check("bounce_deb", 32'(debounced_out), 32'd0);
    check("bounce_deb_chg", 32'(deb_chg), 32'd0);
    check("bounce_rise", 32'(rise_cnt[0]), 32'd0);
    check("bounce_fall", 32'(fall_cnt[0]), 32'd0);

    // 5: both channels rise together.
    clear_counts();
    async_in = 2'b11;
    n = 0;
    while (debounced_out == 2'b00 && n < 20) begin
      cyc();
      n++;
    end
    check("simul_deb", 32'(debounced_out), 32'd3);
    check("simul_rise", 32'(rise_pulse), 32'd3);
    async_in = 2'b00;
    n = 0;
    while (debounced_out != 2'b00 && n < 20) begin
      cyc();
      n++;
    end
    check("simul_release", 32'(debounced_out), 32'd0);
    repeat (4) cyc();

    // 6: reset mid-count; timer phase set by a first reset pulse.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    async_in = 2'b01;
    check("mid_rst_outs", 32'({debounced_out, rise_pulse, fall_pulse}), 32'd0);
    repeat (8) cyc();  // two disagreeing ticks counted
    check("mid_pre_deb", 32'(debounced_out), 32'd0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    clear_counts();
    repeat (11) cyc();
    check("mid_hold_c11", 32'(debounced_out), 32'd0);
    cyc();
    check("mid_rise_c12", 32'(debounced_out), 32'd1);
    check("mid_rise_pulse", 32'(rise_pulse), 32'd1);
    repeat (3) cyc();
    check("mid_rise_cnt", 32'(rise_cnt[0]), 32'd1);

    check("pulse_shape", 32'(pulse_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_button_conditioner
